block_nest_checker: RTL and testbench

//  Streaming keyword-nesting checker for 8-bit character input.

---
 rtl/blkchk_pkg.sv | 52 +++++
 rtl/blkchk_word_matcher.sv | 68 ++++++
 rtl/block_nest_checker.sv | 108 ++++++++++
 tb/tb_block_nest_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/blkchk_pkg.sv
// Shared types and keyword tables for the block nesting checker.
package blkchk_pkg;

  typedef enum logic [1:0] {
    KIND_BEGIN = 2'd0,
    KIND_FORK  = 2'd1,
    KIND_CASE  = 2'd2
  } kind_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_MISMATCH  = 2'd2,
    ERR_OVERFLOW  = 2'd3
  } err_code_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int NUM_KW     = 6;
  localparam int KW_BEGIN   = 0;
  localparam int KW_END     = 1;
  localparam int KW_FORK    = 2;
  localparam int KW_JOIN    = 3;
  localparam int KW_CASE    = 4;
  localparam int KW_ENDCASE = 5;

  // Keyword text, first character at element 0, zero padded to 8 bytes.
  typedef logic [0:7][7:0] kw_str_t;

  localparam kw_str_t KW_STR [NUM_KW] = '{
    {"begin",   24'h0},
    {"end",     40'h0},
    {"fork",    32'h0},
    {"join",    32'h0},
    {"case",    32'h0},
    {"endcase",  8'h0}
  };

  localparam logic [2:0] KW_LEN [NUM_KW] = '{3'd5, 3'd3, 3'd4, 3'd4, 3'd4, 3'd7};

  localparam kind_t KW_KIND [NUM_KW] = '{
    KIND_BEGIN, KIND_BEGIN, KIND_FORK, KIND_FORK, KIND_CASE, KIND_CASE
  };

  // Bit k set when keyword k opens a block.
  localparam logic [NUM_KW-1:0] KW_IS_OPEN = 6'b010101;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? c + 8'h20 : c;
  endfunction

endpackage

// File: rtl/blkchk_word_matcher.sv
// Streaming keyword recogniser: folds case, narrows the candidate set per
// character and reports a single keyword hit when its space delimiter arrives.
module blkchk_word_matcher
  import blkchk_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in,
  output logic        hit_valid,
  output logic        hit_open,
  output kind_t       hit_kind
);

  logic [2:0]        pos;
  logic [NUM_KW-1:0] cand;
  logic [NUM_KW-1:0] cand_next;
  logic [NUM_KW-1:0] hit_vec;
  logic [7:0]        ch;
  logic              is_delim;

  assign ch       = fold_case(in);
  assign is_delim = (ch == CHAR_SPACE);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand_next = '0;
    hit_vec   = '0;
    for (int k = 0; k < NUM_KW; k++) begin
      cand_next[k] = cand[k] && (pos < KW_LEN[k]) && (KW_STR[k][pos] == ch);
      hit_vec[k]   = cand[k] && (KW_LEN[k] == pos);
    end
  end

  // Keyword lengths are distinct within a prefix family, so hit_vec is one-hot.
  always_comb begin
    hit_valid = in_valid && is_delim && (pos != 3'd0) && (|hit_vec);
    hit_open  = 1'b0;
    hit_kind  = KIND_BEGIN;
    for (int k = 0; k < NUM_KW; k++) begin
      if (hit_vec[k]) begin
        hit_open = KW_IS_OPEN[k];
        hit_kind = KW_KIND[k];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos  <= 3'd0;
      cand <= '1;
    end else if (in_valid) begin
      if (is_delim) begin
        if (pos != 3'd0) begin
          pos  <= 3'd0;
          cand <= '1;
        end
      end else begin
        pos  <= (pos == 3'd7) ? 3'd7 : pos + 3'd1;
        cand <= cand_next;
      end
    end
  end

endmodule

// File: rtl/block_nest_checker.sv
// Typed-stack nesting checker for begin/end, fork/join and case/endcase.
// Define BLKCHK_ERR_CODE_EN to add the err_code port (first error latched).
module block_nest_checker
  import blkchk_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             result,
  output logic [CNT_W-1:0] depth,
  output logic             error
`ifdef BLKCHK_ERR_CODE_EN
  ,
  output logic [1:0]       err_code
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] SP_FULL = CNT_W'(DEPTH);

  logic             hit_valid;
  logic             hit_open;
  kind_t            hit_kind;

  kind_t            stack [DEPTH];
  logic [CNT_W-1:0] sp;
  logic [CNT_W-1:0] sp_m1;
  logic [CNT_W-1:0] sp_next;
  logic             full;
  logic             push;
  logic             err_now;

  blkchk_word_matcher u_matcher (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .hit_valid (hit_valid),
    .hit_open  (hit_open),
    .hit_kind  (hit_kind)
  );

  assign sp_m1 = sp - CNT_W'(1);
  assign full  = (sp == SP_FULL);

  always_comb begin
    push    = 1'b0;
    sp_next = sp;
    err_now = 1'b0;
    if (hit_valid) begin
      if (hit_open) begin
        if (full) begin
          err_now = 1'b1;
        end else begin
          push    = 1'b1;
          sp_next = sp + CNT_W'(1);
        end
      end else if (sp == '0) begin
        err_now = 1'b1;
      end else begin
        // A crossed close still pops so depth keeps tracking the text.
        sp_next = sp_m1;
        if (stack[sp_m1[IDX_W-1:0]] != hit_kind) err_now = 1'b1;
      end
    end
  end

  // NOTE: stack storage has no reset; entries at or above sp are never read.
  always_ff @(posedge clk) begin
    if (push && !reset) stack[sp[IDX_W-1:0]] <= hit_kind;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      error <= 1'b0;
    end else begin
      sp    <= sp_next;
      error <= error | err_now;
    end
  end

`ifdef BLKCHK_ERR_CODE_EN
  err_code_t err_kind;
  err_code_t err_q;

  always_comb begin
    err_kind = ERR_MISMATCH;
    if (hit_open)       err_kind = ERR_OVERFLOW;
    else if (sp == '0)  err_kind = ERR_UNDERFLOW;
  end

  always_ff @(posedge clk) begin
    if (reset)                               err_q <= ERR_NONE;
    else if (err_now && (err_q == ERR_NONE)) err_q <= err_kind;
  end

  assign err_code = err_q;
`endif

  assign depth  = sp;
  assign result = ~error & (sp == '0);

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: directed scenarios plus random keyword streams,
// compared every cycle against a word-level reference model (DEPTH 16 and 2).
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in;

  logic       result_a, error_a;
  logic [4:0] depth_a;
  logic       result_b, error_b;
  logic [1:0] depth_b;
`ifdef BLKCHK_ERR_CODE_EN
  logic [1:0] err_code_a, err_code_b;
`endif

  always #5 clk = ~clk;

  block_nest_checker #(.DEPTH(16)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in       (in),
    .result   (result_a),
    .depth    (depth_a),
    .error    (error_a)
`ifdef BLKCHK_ERR_CODE_EN
    ,
    .err_code (err_code_a)
`endif
  );

  block_nest_checker #(.DEPTH(2)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in       (in),
    .result   (result_b),
    .depth    (depth_b),
    .error    (error_b)
`ifdef BLKCHK_ERR_CODE_EN
    ,
    .err_code (err_code_b)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words collected as text, nesting held as a list of kinds.
  int    lim   [2] = '{16, 2};
  int    msp   [2];
  int    mstk  [2][16];
  bit    merr  [2];
  int    mcode [2];
  string word;

  function automatic int kw_id(input string s);
    if (s == "begin")   return 0;
    if (s == "end")     return 1;
    if (s == "fork")    return 2;
    if (s == "join")    return 3;
    if (s == "case")    return 4;
    if (s == "endcase") return 5;
    return -1;
  endfunction

  task automatic model_error(input int m, input int code);
    if (!merr[m]) mcode[m] = code;
    merr[m] = 1'b1;
  endtask

  task automatic model_word(input int id);
    int kind;
    if (id < 0) return;
    kind = id / 2;
    for (int m = 0; m < 2; m++) begin
      if (id % 2 == 0) begin
        if (msp[m] == lim[m]) model_error(m, 3);
        else begin
          mstk[m][msp[m]] = kind;
          msp[m]++;
        end
      end else if (msp[m] == 0) begin
        model_error(m, 1);
      end else begin
        msp[m]--;
        if (mstk[m][msp[m]] != kind) model_error(m, 2);
      end
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [7:0] c);
    logic [7:0] lc;
    if (r) begin
      word = "";
      for (int m = 0; m < 2; m++) begin
        msp[m] = 0; merr[m] = 1'b0; mcode[m] = 0;
      end
    end else if (v) begin
      if (c == 8'h20) begin
        if (word.len() > 0) model_word(kw_id(word));
        word = "";
      end else begin
        lc = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
        word = $sformatf("%s%c", word, lc);
      end
    end
  endtask

  task automatic compare_all();
    check("a_depth",  32'(depth_a),  32'(msp[0]));
    check("a_error",  32'(error_a),  32'(merr[0]));
    check("a_result", 32'(result_a), 32'(!merr[0] && msp[0] == 0));
    check("b_depth",  32'(depth_b),  32'(msp[1]));
    check("b_error",  32'(error_b),  32'(merr[1]));
    check("b_result", 32'(result_b), 32'(!merr[1] && msp[1] == 0));
`ifdef BLKCHK_ERR_CODE_EN
    check("a_err_code", 32'(err_code_a), 32'(mcode[0]));
    check("b_err_code", 32'(err_code_b), 32'(mcode[1]));
`endif
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] c);
    reset    = r;
    in_valid = v;
    in       = c;
    @(posedge clk);
    model_update(r, v, c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      step(1'b0, 1'b1, s[i]);
    end
  endtask

  string toks [12] = '{"begin", "end", "fork", "join", "case", "endcase",
                       "beg", "beginx", "endcasex", "joi", "x", "casez"};

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    string t;
    reset = 1'b1; in_valid = 1'b0; in = 8'h00;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00);
    check("rst_depth",  32'(depth_a),  0);
    check("rst_result", 32'(result_a), 1);
    check("rst_error",  32'(error_a),  0);

    send_str("begin ", 1'b0);
    check("t1_depth_open", 32'(depth_a), 1);
    send_str("end ", 1'b0);
    check("t1_depth_close", 32'(depth_a), 0);
    check("t1_result", 32'(result_a), 1);

    step(1'b1, 1'b0, 8'h00);
    send_str("BeGiN fork ", 1'b0);
    check("t2_depth_peak", 32'(depth_a), 2);
    send_str("JOIN End ", 1'b0);
    check("t2_result", 32'(result_a), 1);

    step(1'b1, 1'b0, 8'h00);
    send_str("begin join ", 1'b0);
    check("t3_error",  32'(error_a),  1);
    check("t3_result", 32'(result_a), 0);
`ifdef BLKCHK_ERR_CODE_EN
    check("t3_err_code", 32'(err_code_a), 2);
`endif
    send_str("end ", 1'b0);
    check("t3_depth_end",  32'(depth_a),  0);
    check("t3_result_end", 32'(result_a), 0);

    step(1'b1, 1'b0, 8'h00);
    send_str("end begin end ", 1'b0);
    check("t4_depth",  32'(depth_a),  0);
    check("t4_result", 32'(result_a), 0);
`ifdef BLKCHK_ERR_CODE_EN
    check("t4_err_code", 32'(err_code_a), 1);
`endif

    step(1'b1, 1'b0, 8'h00);
    send_str("begin case fork ", 1'b0);
    check("t5_depth_b",  32'(depth_b),  2);
    check("t5_result_b", 32'(result_b), 0);
    check("t5_depth_a",  32'(depth_a),  3);
`ifdef BLKCHK_ERR_CODE_EN
    check("t5_err_code_b", 32'(err_code_b), 3);
`endif

    step(1'b1, 1'b0, 8'h00);
    send_str("  beginx endcasex case   endcase ", 1'b1);
    check("t6_result", 32'(result_a), 1);
    check("t6_depth",  32'(depth_a),  0);
    send_str("beg", 1'b0);
    step(1'b1, 1'b0, 8'h00);
    send_str("in ", 1'b0);
    check("t6_reset_depth",  32'(depth_a),  0);
    check("t6_reset_result", 32'(result_a), 1);

    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++) send_str("begin ", 1'b0);
    check("ovf16_depth", 32'(depth_a), 16);
    check("ovf16_error", 32'(error_a), 1);

    step(1'b1, 1'b0, 8'h00);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 60) == 0) step(1'b1, 1'($urandom_range(0, 1)), 8'h20);
      t = toks[$urandom_range(0, 11)];
      for (int i = 0; i < t.len(); i++) begin
        if ($urandom_range(0, 1) == 1) t[i] = t[i] - 8'h20;
      end
      send_str(t, 1'b1);
      repeat ($urandom_range(1, 2)) step(1'b0, 1'b1, 8'h20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
